approx_prod_accumulator: RTL

//  Streaming accumulator directly downstream of the 8x8 approximate multiplier.

---
 rtl/approx_prod_accumulator.sv | 103 ++++++++++
 1 files changed

// File: rtl/approx_prod_accumulator.sv
// Packet accumulator behind the approximate multiplier: sums in_last-delimited product
// beats and hands sum/count/overflow downstream. Define ACC_SAT_EN for saturating accumulation.
module approx_prod_accumulator #(
  parameter  int PROD_W  = 16,
  parameter  int ACC_W   = 24,
  parameter  int MAX_LEN = 256,
  localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               beat;
  logic [ACC_W:0]     sum_ext;
  logic               carry;
  logic [ACC_W-1:0]   acc_add;
  logic [CNT_W-1:0]   cnt_inc;
  logic               at_max;

  assign in_ready = (state_q != S_HOLD);
  assign beat     = in_valid & in_ready;

  always_comb begin
    sum_ext = {1'b0, acc_q} + (ACC_W+1)'(in_prod);
    carry   = sum_ext[ACC_W];
`ifdef ACC_SAT_EN
    // once clamped, any further non-zero product carries again, so acc stays pinned
    acc_add = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_add = sum_ext[ACC_W-1:0];
`endif
    cnt_inc = cnt_q + CNT_W'(1);
    at_max  = (cnt_inc == CNT_W'(MAX_LEN));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (beat) begin
          acc_d   = ACC_W'(in_prod);
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = (in_last || (MAX_LEN == 1)) ? S_HOLD : S_ACC;
        end
      end
      S_ACC: begin
        if (beat) begin
          acc_d   = acc_add;
          cnt_d   = cnt_inc;
          ovf_d   = ovf_q | carry;
          // in_last and MAX_LEN on the same beat still close just once
          state_d = (in_last || at_max) ? S_HOLD : S_ACC;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    out_valid    = (state_q == S_HOLD);
    out_sum      = out_valid ? acc_q : '0;
    out_count    = out_valid ? cnt_q : '0;
    out_overflow = out_valid & ovf_q;
  end

endmodule
